// File: rtl/stream_cipher_core.sv
// Three-register keystream generator with a valid/ready XOR datapath for encrypt/decrypt.
// Optional warm-up phase after each seed load is enabled by defining STREAM_CIPHER_WARMUP_EN.
module stream_cipher_core #(
   parameter int REG_W  = 16,
   parameter int DATA_W = 8,
   parameter int WARMUP = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  seed,
   input  logic              seed_load,
   input  logic              zeroize,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              seed_err,
   output logic [1:0]        fsm_state
);

   // Handshakes: a word moves on a rising edge where valid and ready are both high;
   // valid never waits on ready, and out_data/out_valid hold until out_ready is seen.

   localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef STREAM_CIPHER_WARMUP_EN
   localparam logic [1:0] ST_WARMUP = 2'd1;
   localparam int         WARM_CW   = 10;
`endif
   localparam logic [1:0] ST_GEN    = 2'd2;
   localparam logic [1:0] ST_READY  = 2'd3;

   localparam int               CNT_W     = $clog2(DATA_W + 1);
   localparam logic [REG_W-1:0] SEED_MASK = {REG_W/8{8'hA5}};

   logic [1:0]        state_q;
   logic [REG_W-1:0]  a_q;
   logic [REG_W-1:0]  b_q;
   logic [REG_W-1:0]  c_q;
   logic [DATA_W-1:0] ks_q;
   logic [CNT_W-1:0]  bit_cnt_q;
`ifdef STREAM_CIPHER_WARMUP_EN
   logic [WARM_CW-1:0] warm_cnt_q;
`else
   logic unused_warmup;
   assign unused_warmup = (WARMUP > 0);
`endif

   logic [REG_W-1:0] a_step;
   logic [REG_W-1:0] b_step;
   logic [REG_W-1:0] c_step;
   logic [REG_W-1:0] seed_rot;
   logic             ks_bit;
   logic             seed_ok;
   logic             seed_accept;
   logic             in_fire;
   logic             out_fire;
   logic             bit_last;

   assign ks_bit = a_q[0] ^ b_q[0] ^ c_q[0];
   assign a_step = {a_q[REG_W-2:0], b_q[0] ^ c_q[1]};
   assign b_step = {b_q[REG_W-2:0], c_q[3] ^ a_q[1]};
   assign c_step = {c_q[REG_W-2:0], a_q[5] ^ b_q[2]};

   // Rotation by exactly half the width, so left and right rotate coincide.
   assign seed_rot    = {seed[REG_W/2-1:0], seed[REG_W-1:REG_W/2]};
   assign seed_ok     = (seed != '0) && (seed != '1);
   assign seed_accept = seed_load && seed_ok && !zeroize;

   // A seed load or zeroize in the same cycle wins over the data path, so ready drops.
   assign in_ready = (state_q == ST_READY) && (!out_valid || out_ready) &&
                     !zeroize && !seed_accept;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign bit_last = (bit_cnt_q == CNT_W'(DATA_W - 1));

`ifdef STREAM_CIPHER_WARMUP_EN
   assign busy = (state_q == ST_WARMUP) || (state_q == ST_GEN);
`else
   assign busy = (state_q == ST_GEN);
`endif
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         ks_q       <= '0;
         bit_cnt_q  <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         seed_err   <= 1'b0;
`ifdef STREAM_CIPHER_WARMUP_EN
         warm_cnt_q <= '0;
`endif
      end else begin
         seed_err <= seed_load && !seed_ok && !zeroize;
         if (zeroize) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            ks_q       <= '0;
            bit_cnt_q  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
`ifdef STREAM_CIPHER_WARMUP_EN
            warm_cnt_q <= '0;
`endif
         end else if (seed_accept) begin
            a_q        <= seed;
            b_q        <= ~seed_rot;
            c_q        <= seed ^ SEED_MASK;
            ks_q       <= '0;
            bit_cnt_q  <= '0;
            out_valid  <= 1'b0;
`ifdef STREAM_CIPHER_WARMUP_EN
            warm_cnt_q <= '0;
            state_q    <= ST_WARMUP;
`else
            state_q    <= ST_GEN;
`endif
         end else begin
            // A rejected seed has no effect here; only seed_err reports it.
            if (out_fire) out_valid <= 1'b0;
            case (state_q)
`ifdef STREAM_CIPHER_WARMUP_EN
               ST_WARMUP: begin
                  a_q <= a_step;
                  b_q <= b_step;
                  c_q <= c_step;
                  if (warm_cnt_q == WARM_CW'(WARMUP - 1)) begin
                     warm_cnt_q <= '0;
                     state_q    <= ST_GEN;
                  end else begin
                     warm_cnt_q <= warm_cnt_q + WARM_CW'(1);
                  end
               end
`endif
               ST_GEN: begin
                  a_q  <= a_step;
                  b_q  <= b_step;
                  c_q  <= c_step;
                  ks_q <= DATA_W'({ks_q, ks_bit});
                  if (bit_last) begin
                     bit_cnt_q <= '0;
                     state_q   <= ST_READY;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
               ST_READY: begin
                  // Overrides the out_fire clear above: consume and refill in one edge.
                  if (in_fire) begin
                     out_data  <= in_data ^ ks_q;
                     out_valid <= 1'b1;
                     ks_q      <= '0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_GEN;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: doc/stream_cipher_core.md
STREAM_CIPHER_CORE -- requirements
Module: stream_cipher_core

Interface
REQ-001 Parameter REG_W, default 16: width of each of the three shift registers A, B, C; legal values are multiples of 8 and at least 8.
REQ-002 Parameter DATA_W, default 8: width of one data/keystream word; legal range is 1 to 32.
REQ-003 Parameter WARMUP, default 64: number of discarded warm-up clocks after a seed load; legal range is 1 to 1023.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port seed, input, REG_W bits: key/seed value.
REQ-007 Port seed_load, input, 1 bit: single-cycle request to load seed.
REQ-008 Port zeroize, input, 1 bit: synchronous clear of all key material.
REQ-009 Port in_data, input, DATA_W bits, with in_valid (input, 1) and in_ready (output, 1): plaintext/ciphertext input handshake.
REQ-010 Port out_data, output, DATA_W bits, with out_valid (output, 1) and out_ready (input, 1): result output handshake.
REQ-011 Port busy, output, 1 bit: high in WARMUP and GEN.
REQ-012 Port seed_err, output, 1 bit: one-cycle pulse when a seed is rejected.

Function
REQ-013 States are IDLE, WARMUP, GEN and READY.
REQ-014 Each clock in WARMUP or GEN, the registers SHALL step as follows; in all other states A, B and C hold.
- A <= {A[REG_W-2:0], B[0]^C[1]}
- B <= {B[REG_W-2:0], C[3]^A[1]}
- C <= {C[REG_W-2:0], A[5]^B[2]}
REQ-015 The keystream bit is z = A[0]^B[0]^C[0], taken before the step.
- In GEN, z shifts into a DATA_W keystream buffer at the LSB.
- The first bit collected ends up in the MSB.
REQ-016 Seed load is accepted when seed_load=1 and seed is neither all-0 nor all-1. On acceptance:
- A <= seed.
- B <= ~rotl(seed, REG_W/2).
- C <= seed ^ {REG_W/8{8'hA5}}.
- The bit counter and keystream buffer clear.
- out_valid clears.
- Next state is WARMUP (GEN when the warm-up macro is absent).
REQ-017 An all-0 or all-1 seed with seed_load=1 SHALL leave state unchanged and pulse seed_err for exactly one cycle.
REQ-018 Seed load is accepted in every state and aborts any operation in progress; a held output word is discarded.
REQ-019 WARMUP lasts exactly WARMUP clocks, then moves to GEN; keystream is not collected during WARMUP.
REQ-020 GEN lasts exactly DATA_W clocks, then moves to READY.
REQ-021 in_ready=1 only in READY and only when out_valid=0 or out_ready=1.
REQ-022 On in_valid && in_ready, out_data <= in_data ^ keystream buffer, out_valid <= 1, and the state goes to GEN with the buffer and counter cleared.
REQ-023 out_valid and out_data hold stable until out_ready=1; output acceptance and a new input acceptance in the same cycle are both honoured with no bubble.
REQ-024 Each keystream word is used exactly once; no word is skipped or reused across stalls.
REQ-025 zeroize=1 takes priority over seed_load. It clears:
- A, B and C to 0.
- The keystream buffer and the counter.
- out_data and out_valid.
Next state is IDLE.
REQ-026 In IDLE, in_ready=0 and in_valid is ignored.

Reset
REQ-027 While rst_n=0, the block SHALL be in the following state.
- State is IDLE.
- A, B, C, the keystream buffer and the counters are 0.
- out_data=0; out_valid, in_ready, busy and seed_err are 0.
REQ-028 The first seed_load is honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro STREAM_CIPHER_WARMUP_EN selects warm-up behaviour.
- Defined: the WARMUP state and counter exist as in REQ-019.
- Undefined: there is no WARMUP state or counter, an accepted seed goes directly to GEN, and the WARMUP parameter is ignored.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, no stimulus: all outputs 0 for 20 cycles.
- Defaults, macro on, seed=16'h1234: busy high for 64+8 cycles, then in_ready=1; in_data=8'h00 gives out_data equal to the model keystream word; a second run with the same seed gives an identical word.
- seed=16'h0000, then 16'hFFFF: seed_err pulses one cycle each, state stays IDLE.
- out_ready held 0 with 3 inputs offered: the first result is held stable, in_ready stays 0 after the next keystream completes, and on release the words are consumed in order with none skipped.
- Encrypt 8'h5A, reload the same seed, decrypt the result: 8'h5A is recovered.
- zeroize asserted together with seed_load mid-GEN: next cycle IDLE, out_valid=0, seed_err=0.
